// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, ALU classes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12,
    S_JAL      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam int WAIT_CNT_W = 8;

  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Controller <-> datapath/memory bundle; master is the control FSM, slave the datapath side.
interface mips_mc_control_if #(parameter int PC_W = 16);
  logic [5:0]      opcode;
  logic [25:0]     jtarget;
  logic [PC_W-1:0] alu_result;
  logic            zero;
  logic            mem_ready;
  logic [PC_W-1:0] pc;
  logic            ir_write, mem_read, mem_write, i_or_d;
  logic            reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]      alu_src_b, alu_op;
  logic [3:0]      state;
  logic            trap;

  modport master (
    input  opcode, jtarget, alu_result, zero, mem_ready,
    output pc, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, state, trap
  );

  modport slave (
    output opcode, jtarget, alu_result, zero, mem_ready,
    input  pc, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, state, trap
  );
endinterface

// File: rtl/mips_wait_timer.sv
// Memory-wait counter: clears whenever the handshake completes or no wait is pending.
module mips_wait_timer
  import mips_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (active && !ready) cnt_d = cnt_q + WAIT_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // ready on the terminal cycle wins over the timeout
  assign timeout = active && !ready && (cnt_q == WAIT_CNT_W'(WAIT_MAX));

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with memory-wait timeout trap.
// Optional JAL support is built when MIPS_MC_JAL_EN is defined.
//
// state    | meaning
// FETCH    | read instruction, pc += 4 on mem_ready
// DECODE   | branch on opcode
// MEM_ADDR | compute lw/sw address
// MEM_RD   | data read, wait for mem_ready
// MEM_WB   | load result to register file
// MEM_WR   | data write, wait for mem_ready
// EXEC_R   | R-type ALU op
// R_WB     | R-type writeback (rd)
// EXEC_I   | addi ALU op
// I_WB     | addi writeback (rt)
// BRANCH   | beq compare, load target on zero
// JUMP     | pseudo-direct jump
// JAL      | link write of pc, then JUMP
// TRAP     | absorbing fault
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int WAIT_MAX = 15
) (
  input logic                clk,
  input logic                reset,
  mips_mc_control_if.master  bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            is_sw_q, is_sw_d;
  logic            run_q, run_d;
  logic            timeout;
  logic [27:0]     jaddr;
  logic [PC_W-1:0] jump_pc;

  assign jaddr = {bus.jtarget, 2'b00};

  if (PC_W > 28) begin : g_jseg
    assign jump_pc = {pc_q[PC_W-1:28], jaddr};
  end else begin : g_jtrunc
    assign jump_pc = jaddr[PC_W-1:0];
  end

  mips_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst_n   (reset),
    .active  (run_q && is_wait_state(state_q)),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  // run_q holds everything idle for the first clock after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      is_sw_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      is_sw_q <= is_sw_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    is_sw_d        = is_sw_q;
    run_d          = 1'b1;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = ALU_ADD;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            pc_d         = pc_q + PC_W'(4);
            state_d      = S_DECODE;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          case (bus.opcode)
            OP_RTYPE: state_d = S_EXEC_R;
            OP_LW:    begin state_d = S_MEM_ADDR; is_sw_d = 1'b0; end
            OP_SW:    begin state_d = S_MEM_ADDR; is_sw_d = 1'b1; end
            OP_ADDI:  state_d = S_EXEC_I;
            OP_BEQ:   state_d = S_BRANCH;
            OP_J:     state_d = S_JUMP;
`ifdef MIPS_MC_JAL_EN
            OP_JAL:   state_d = S_JAL;
`endif
            default:  state_d = S_TRAP;
          endcase
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_d       = is_sw_q ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (bus.mem_ready) state_d = S_MEM_WB;
          else if (timeout)  state_d = S_TRAP;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          state_d        = S_FETCH;
        end
        S_MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
          else if (timeout)  state_d = S_TRAP;
        end
        S_EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_FUNCT;
          state_d       = S_R_WB;
        end
        S_R_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
          state_d       = S_FETCH;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_d       = S_I_WB;
        end
        S_I_WB: begin
          bus.reg_write = 1'b1;
          state_d       = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_SUB;
          if (bus.zero) pc_d = bus.alu_result;
          state_d = S_FETCH;
        end
        S_JUMP: begin
          pc_d    = jump_pc;
          state_d = S_FETCH;
        end
`ifdef MIPS_MC_JAL_EN
        // pc already points past the jal, so the datapath links it as-is
        S_JAL: begin
          bus.reg_write = 1'b1;
          state_d       = S_JUMP;
        end
`endif
        default: state_d = S_TRAP;
      endcase
    end
  end

  assign bus.pc    = pc_q;
  assign bus.state = state_q;
  assign bus.trap  = (state_q == S_TRAP);

endmodule
